// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore FSM sequencing instruction fetch, PC update and
// execute handoff for the 8-bit CPU. Holds the instruction register and
// drives PC enable/inc plus the memory read strobe.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   run          sequence instructions (sampled at IDLE/EXEC-done/BRANCH)
//   mem_ready    instr_in valid this cycle
//   instr_in     instruction word from memory
//   exec_done    execute datapath finished current instruction
//   branch_taken qualifies exec_done; 1 = PC loads external target
//   mem_read     read request at current PC (FETCH)
//   pc_enable    PC enable (INCR, BRANCH)
//   pc_inc       PC increment (1) / load (0)
//   ir           instruction register
//   exec_valid   ir valid, execute in progress
//   halted       FSM in HALT
//   instr_count  retired-instruction count
//
// Build option: define FETCH_SEQ_RETIRE_COUNT_EN to enable the saturating
// retire counter; otherwise instr_count is tied to zero.
module fetch_sequencer #(
  parameter int unsigned             DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]   HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  output logic                  mem_read,
  output logic                  pc_enable,
  output logic                  pc_inc,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  exec_valid,
  output logic                  halted,
  output logic [15:0]           instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    INCR   = 3'd2,
    EXEC   = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and IR load.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          ir_d    = instr_in;
          state_d = INCR;
        end
      end
      INCR:   state_d = (ir_q == HALT_OPCODE) ? HALT : EXEC;
      EXEC: begin
        if (exec_done) begin
          if (branch_taken) state_d = BRANCH;
          else if (run)     state_d = FETCH;
          else              state_d = IDLE;
        end
      end
      BRANCH: state_d = run ? FETCH : IDLE;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: state register only.
  always_comb begin
    mem_read   = 1'b0;
    pc_enable  = 1'b0;
    pc_inc     = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH:  mem_read = 1'b1;
      INCR: begin
        pc_enable = 1'b1;
        pc_inc    = 1'b1;
      end
      EXEC:   exec_valid = 1'b1;
      BRANCH: pc_enable  = 1'b1;
      HALT:   halted     = 1'b1;
      default: ;
    endcase
  end

  assign ir = ir_q;

`ifdef FETCH_SEQ_RETIRE_COUNT_EN
  logic        retire;
  logic [15:0] cnt_q, cnt_d;

  // A HALT opcode retires in INCR since it never reaches EXEC.
  assign retire = ((state_q == EXEC) && exec_done) ||
                  ((state_q == INCR) && (ir_q == HALT_OPCODE));

  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, mem_ready, exec_done, branch_taken;
  logic [7:0]  instr_in;
  logic        mem_read, pc_enable, pc_inc, exec_valid, halted;
  logic [7:0]  ir;
  logic [15:0] instr_count;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_WIDTH (8),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_ready   (mem_ready),
    .instr_in    (instr_in),
    .exec_done   (exec_done),
    .branch_taken(branch_taken),
    .mem_read    (mem_read),
    .pc_enable   (pc_enable),
    .pc_inc      (pc_inc),
    .ir          (ir),
    .exec_valid  (exec_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // Expected outputs for one cycle.
  typedef struct packed {
    logic        mem_read;
    logic        pc_enable;
    logic        pc_inc;
    logic        exec_valid;
    logic        halted;
    logic [7:0]  ir;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  model_ir  = 8'h00;
  logic [15:0] model_cnt = 16'h0000;

  function automatic exp_t mk(input logic mr, pe, pi, ev, h);
    exp_t e;
    e.mem_read   = mr;
    e.pc_enable  = pe;
    e.pc_inc     = pi;
    e.exec_valid = ev;
    e.halted     = h;
    e.ir         = model_ir;
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    e.cnt        = model_cnt;
`else
    e.cnt        = 16'h0000;
`endif
    return e;
  endfunction

  function automatic void retire();
    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
  endfunction

  // Per-cycle comparison against the transaction-level expectation queue.
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e, a;
      e = expq.pop_front();
      a = {mem_read, pc_enable, pc_inc, exec_valid, halted, ir, instr_count};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t got mr/pe/pi/ev/h=%b%b%b%b%b ir=%h cnt=%h expected %b%b%b%b%b ir=%h cnt=%h",
                 $time, a.mem_read, a.pc_enable, a.pc_inc, a.exec_valid, a.halted, a.ir, a.cnt,
                 e.mem_read, e.pc_enable, e.pc_inc, e.exec_valid, e.halted, e.ir, e.cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, record expected outputs of this cycle.
  task automatic cyc(input logic r, input logic mr, input logic [7:0] din,
                     input logic done, input logic br, input exp_t e);
    @(posedge clk);
    #1;
    run = r; mem_ready = mr; instr_in = din; exec_done = done; branch_taken = br;
    expq.push_back(e);
  endtask

  // One instruction starting in FETCH: fw wait cycles before mem_ready,
  // ew wait cycles before exec_done (branch_taken held high while waiting).
  task automatic instr_txn(input logic [7:0] d, input int unsigned fw, input int unsigned ew,
                           input logic br, input logic rn);
    for (int unsigned i = 0; i <= fw; i++)
      cyc(rn, i == fw, (i == fw) ? d : 8'($urandom), 1'($urandom), 1'($urandom), mk(1, 0, 0, 0, 0));
    model_ir = d;
    cyc(rn, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), mk(0, 1, 1, 0, 0));
    if (d == 8'hFF) begin
      retire();
      return;
    end
    for (int unsigned i = 0; i <= ew; i++)
      cyc(rn, 1'($urandom), 8'($urandom), i == ew, (i == ew) ? br : 1'b1, mk(0, 0, 0, 1, 0));
    retire();
    if (br)
      cyc(rn, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), mk(0, 1, 0, 0, 0));
  endtask

  task automatic idle(input int unsigned n, input logic go);
    for (int unsigned i = 0; i < n; i++)
      cyc((i == n - 1) ? go : 1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          mk(0, 0, 0, 0, 0));
  endtask

  task automatic halt_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 1));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; instr_in = 8'h12;
    exec_done = 1'b1; branch_taken = 1'b0;
    expq.push_back(mk(0, 0, 0, 0, 0));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    model_ir  = 8'h00;
    model_cnt = 16'h0000;
    chk("rst_async_pc_enable", {31'd0, pc_enable}, 32'd0);
    chk("rst_async_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_async_halted", {31'd0, halted}, 32'd0);
    chk("rst_async_ir", {24'd0, ir}, 32'h00);
    chk("rst_async_count", {16'd0, instr_count}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; instr_in = 8'h12;
    exec_done = 1'b1; branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_pc_enable", {31'd0, pc_enable}, 32'd0);
    chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ir", {24'd0, ir}, 32'h00);
    chk("rst_count", {16'd0, instr_count}, 32'h0);

    // Back-to-back 3-cycle instructions.
    release_reset();
    instr_txn(8'h12, 0, 0, 1'b0, 1'b1);
    #2 chk("first_ir", {24'd0, ir}, 32'h12);
    chk("first_exec_valid", {31'd0, exec_valid}, 32'd1);
    instr_txn(8'h12, 0, 0, 1'b0, 1'b1);
    instr_txn(8'h12, 0, 0, 1'b0, 1'b1);
    // Memory wait states.
    instr_txn(8'h34, 4, 0, 1'b0, 1'b1);
    // Exec wait with branch_taken ignored, then a taken branch.
    instr_txn(8'h56, 2, 3, 1'b1, 1'b1);
    #2 chk("branch_pc_enable", {31'd0, pc_enable}, 32'd1);
    chk("branch_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("branch_ir", {24'd0, ir}, 32'h56);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    chk("count_after_5", {16'd0, instr_count}, 32'd5);
`else
    chk("count_tied_zero", {16'd0, instr_count}, 32'd0);
`endif
    // run dropped: complete, go idle, restart.
    instr_txn(8'h78, 0, 1, 1'b0, 1'b0);
    idle(3, 1'b1);
    instr_txn(8'h9A, 1, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    @(negedge clk);
    #1 force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    model_cnt = 16'hFFFE;
`endif
    idle(1, 1'b1);
    instr_txn(8'h01, 0, 0, 1'b0, 1'b1);
    instr_txn(8'h02, 0, 0, 1'b0, 1'b1);
    instr_txn(8'h03, 0, 0, 1'b0, 1'b1);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    #2 chk("count_saturated", {16'd0, instr_count}, 32'hFFFF);
`endif

    // Reset in the middle of an execute phase.
    cyc(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, mk(1, 0, 0, 0, 0));
    model_ir = 8'hC3;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mk(0, 1, 1, 0, 0));
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, mk(0, 0, 0, 1, 0));
    async_reset();
    cyc(1'b1, 1'b1, 8'h44, 1'b1, 1'b1, mk(0, 0, 0, 0, 0));

    // HALT opcode, held for 20 cycles, left only by reset.
    release_reset();
    instr_txn(8'hFF, 0, 0, 1'b0, 1'b1);
    halt_cycles(20);
    #2 chk("halt_halted", {31'd0, halted}, 32'd1);
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
    chk("halt_retired", {16'd0, instr_count}, 32'd1);
`endif
    async_reset();
    release_reset();
    instr_txn(8'h12, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Moore FSM that sequences instruction fetch, program-counter update and execute handoff for the 8-bit CPU.
Drives the enable/inc controls of the program counter register and the memory read strobe, and holds the instruction register.
Hands each instruction to the execute datapath with an exec_valid/exec_done handshake.
The PC load value (branch target) is routed externally; this block only decides when the PC increments or loads.

Parameters:
DATA_WIDTH, 8, width of instruction word and instruction register
HALT_OPCODE, 8'hFF, IR value that enters HALT without an execute phase

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = sequence instructions; sampled only at decision points
mem_ready  input  1  memory has valid instr_in this cycle
instr_in  input  DATA_WIDTH  instruction word from memory
exec_done  input  1  execute datapath finished current instruction
branch_taken  input  1  qualifies exec_done; 1 = load PC from external target
mem_read  output  1  request instruction read at current PC
pc_enable  output  1  to PC enable
pc_inc  output  1  to PC inc (1 = increment, 0 = load)
ir  output  DATA_WIDTH  instruction register
exec_valid  output  1  ir valid, execute in progress
halted  output  1  FSM in HALT
instr_count  output  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=IDLE, ir=0, instr_count=0; all control outputs 0.
- All control outputs decode from the state register only. They never depend combinationally on inputs.
- States and outputs:
  - IDLE: all controls 0. run=1 -> FETCH; else stay.
  - FETCH: mem_read=1. Stay while mem_ready=0. mem_ready=1 -> ir<=instr_in, -> INCR.
  - INCR: pc_enable=1, pc_inc=1 for exactly one cycle. If ir==HALT_OPCODE -> HALT, else -> EXEC.
  - EXEC: exec_valid=1. Stay while exec_done=0. On exec_done=1:
    - branch_taken=1 -> BRANCH;
    - else run=1 -> FETCH;
    - else -> IDLE.
  - BRANCH: pc_enable=1, pc_inc=0 for exactly one cycle (PC loads target). Then run=1 -> FETCH, else -> IDLE.
  - HALT: halted=1, other controls 0. Exits only via reset.
- Illegal or unused state encodings -> IDLE on the next clock.
- Latency:
  - Minimum 3 cycles per non-branch instruction (FETCH, INCR, EXEC with mem_ready and exec_done both high on first cycle).
  - A branch adds 1 cycle.
- run deassertion mid-FETCH or mid-EXEC does not abort. The current instruction completes, then the FSM goes to IDLE.
- branch_taken is ignored when exec_done=0.
- Retirement: one instruction retires on the exec_done=1 cycle in EXEC. HALT_OPCODE retires on the INCR cycle.
- ir holds its value in all states except the FETCH cycle with mem_ready=1.
- pc_enable and mem_read are never high in the same cycle.
- Reset asserted mid-operation: immediate return to reset values. No PC pulse is generated.

Optional Feature:
- Macro: FETCH_SEQ_RETIRE_COUNT_EN.
- Defined: instr_count increments by 1 on each retirement and saturates at 16'hFFFF (no wrap). It is cleared only by reset.
- Undefined: the counter logic is absent and instr_count is tied to 0.
- The port exists in both builds.

Test Plan:
- Reset held, then released with run=1, mem_ready=1, exec_done=1, instr_in=8'h12:
  - cycle 1 FETCH (mem_read=1), cycle 2 INCR (pc_enable=1, pc_inc=1, ir=8'h12), cycle 3 EXEC (exec_valid=1);
  - sequence repeats every 3 cycles.
- mem_ready low for 4 cycles in FETCH -> mem_read high 5 cycles, ir unchanged until the ready cycle, single INCR pulse.
- exec_done with branch_taken=1 -> exactly one cycle pc_enable=1, pc_inc=0, then FETCH.
  - branch_taken=1 with exec_done=0 -> no BRANCH.
- instr_in=8'hFF -> INCR then HALT (halted=1).
  - Stays in HALT for 20 cycles regardless of run, mem_ready and exec_done.
  - reset=0 -> IDLE.
- run dropped during EXEC -> exec_done completes the instruction, FSM -> IDLE with no mem_read.
  - run=1 again -> FETCH next cycle.
- FETCH_SEQ_RETIRE_COUNT_EN defined:
  - 5 instructions -> instr_count=5;
  - force count near 16'hFFFE, retire 3 -> holds 16'hFFFF;
  - undefined build -> instr_count stays 0.
